// File: rtl/pool2d_stream.sv
// Streaming P x P non-overlapping pooler (max / average) over an M x M raster frame.
// One row accumulator plus a per-window-column partial buffer; registered valid/ready output.
module pool2d_stream #(
  parameter int N = 16,
  parameter int Q = 12,
  parameter int M = 12,
  parameter int P = 3,
  parameter logic [N-1:0] PSQR_INV = 16'h01C7
) (
  input  logic         clk,
  input  logic         master_rst,
  input  logic         ce,
  input  logic         clr,
  input  logic         mode,
  input  logic [N-1:0] psqr_inv,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last
);
  localparam int ACC_W = N + 2 * $clog2(P);
  localparam int WN    = M / P;
  localparam int CW    = (M > 1) ? $clog2(M) : 1;
  localparam int PW    = (P > 1) ? $clog2(P) : 1;
  localparam int WW    = (WN > 1) ? $clog2(WN) : 1;
  localparam int PRW   = ACC_W + N;
  localparam logic signed [PRW-1:0] SMAX = PRW'((2 ** (N - 1)) - 1);
  localparam logic signed [PRW-1:0] SMIN = -SMAX - PRW'(1);

  logic [CW-1:0] col, row;
  logic [WW-1:0] wcol;
  logic [PW-1:0] cph, rph;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] pbuf [WN];
  logic          mode_q;
  logic [N-1:0]  psqr_q;

  logic accept, frame_start, m_eff, col_start, col_end, row_start, row_end, load, last_win;
  logic [N-1:0] ps_eff, avg_val, res_val;
  logic signed [ACC_W-1:0] px, seg, res;
  logic signed [PRW-1:0] prod, sh;

  function automatic logic signed [ACC_W-1:0] f(input logic signed [ACC_W-1:0] a,
                                                input logic signed [ACC_W-1:0] b,
                                                input logic m);
    if (m) f = (a > b) ? a : b;
    else   f = a + b;
  endfunction

  assign in_ready    = ce & master_rst & (~out_valid | out_ready);
  assign accept      = in_valid & in_ready;
  assign frame_start = (row == '0) && (col == '0);
  // The first pixel of a frame already runs under the mode/multiplier being latched.
  assign m_eff       = frame_start ? mode : mode_q;
  assign ps_eff      = frame_start ? psqr_inv : psqr_q;
  assign col_start   = (cph == '0);
  assign col_end     = (cph == PW'(P - 1));
  assign row_start   = (rph == '0);
  assign row_end     = (rph == PW'(P - 1));
  assign px          = {{(ACC_W - N){in_data[N-1]}}, in_data};
  assign seg         = f(acc, px, m_eff);
  assign res         = f(pbuf[wcol], seg, m_eff);
  assign load        = accept & col_end & row_end;
  assign last_win    = (row == CW'(M - 1)) && (wcol == WW'(WN - 1));

  assign prod = PRW'(res) * PRW'($signed(ps_eff));
  assign sh   = prod >>> Q;

  always_comb begin
    avg_val = sh[N-1:0];
    if (sh > SMAX)      avg_val = SMAX[N-1:0];
    else if (sh < SMIN) avg_val = SMIN[N-1:0];
    res_val = m_eff ? res[N-1:0] : avg_val;
  end

  always_ff @(posedge clk or negedge master_rst) begin
    if (!master_rst) begin
      col <= '0; row <= '0; wcol <= '0; cph <= '0; rph <= '0;
      acc <= '0; mode_q <= 1'b1; psqr_q <= PSQR_INV;
      for (int i = 0; i < WN; i++) pbuf[i] <= '0;
    end else if (ce) begin
      if (clr) begin
        col <= '0; row <= '0; wcol <= '0; cph <= '0; rph <= '0;
        acc <= '0;
        for (int i = 0; i < WN; i++) pbuf[i] <= '0;
      end else if (accept) begin
        if (frame_start) begin
          mode_q <= mode;
          psqr_q <= psqr_inv;
        end
        acc <= col_start ? px : seg;
        if (col_end) begin
          if (row_start)     pbuf[wcol] <= seg;
          else if (!row_end) pbuf[wcol] <= res;
        end
        if (col == CW'(M - 1)) begin
          col <= '0; cph <= '0; wcol <= '0;
          if (row == CW'(M - 1)) begin
            row <= '0; rph <= '0;
          end else begin
            row <= row + CW'(1);
            rph <= row_end ? '0 : rph + PW'(1);
          end
        end else begin
          col <= col + CW'(1);
          if (col_end) begin
            cph  <= '0;
            wcol <= wcol + WW'(1);
          end else begin
            cph <= cph + PW'(1);
          end
        end
      end
    end
  end

  // Output register: a new load wins over a same-cycle transfer, so nothing is dropped.
  always_ff @(posedge clk or negedge master_rst) begin
    if (!master_rst) begin
      out_valid <= 1'b0; out_data <= '0; out_last <= 1'b0;
    end else if (ce) begin
      if (clr) begin
        out_valid <= 1'b0; out_last <= 1'b0;
      end else if (load) begin
        out_valid <= 1'b1; out_data <= res_val; out_last <= last_win;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0; out_data <= '0; out_last <= 1'b0;
      end
    end
  end
endmodule
